// File: rtl/duty_ramp_ctrl.sv
// Duty-cycle ramp controller: slews a 0..100 % duty toward a loaded target at a programmable tick rate.
// Optional macro DUTY_RAMP_CLAMP_EN clamps the loaded target to MAX_DUTY instead of 100.
`timescale 1ns/1ps
module duty_ramp_ctrl #(
  parameter int SYS_CLK_FREQ = 125_000_000,
  parameter int TICK_DIV     = 125_000,
  parameter int MAX_DUTY     = 90
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [6:0] target,
  input  logic       load,
  input  logic [7:0] rate,
  input  logic       estop,
  output logic [6:0] duty,
  output logic       busy,
  output logic       dir,
  output logic       done
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

`ifdef DUTY_RAMP_CLAMP_EN
  localparam logic [6:0] CLAMP_MAX = 7'(MAX_DUTY);
`else
  localparam logic [6:0] CLAMP_MAX = 7'd100;
`endif

  generate
    if (TICK_DIV < 1 || SYS_CLK_FREQ < TICK_DIV || MAX_DUTY < 0 || MAX_DUTY > 100) begin : g_bad_cfg
      $error("duty_ramp_ctrl: invalid parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} state_t;

  state_t          r_state, w_state_next;
  logic [6:0]      r_duty, w_duty_next;
  logic [6:0]      r_target_q, w_target_next;
  logic [7:0]      r_rate_q, w_rate_next;
  logic [TW-1:0]   r_tick_cnt, w_tick_next;
  logic [7:0]      r_step_cnt, w_step_next;
  logic            r_pend, w_pend_next;
  logic            r_done_pend, w_done_pend_next;
  logic            r_done, w_done_next;

  logic [6:0]      w_target_clamped;
  logic            w_tick;
  logic            w_step;
  logic [6:0]      w_duty_step;

  assign w_target_clamped = (target > CLAMP_MAX) ? CLAMP_MAX : target;
  assign w_tick = (r_tick_cnt == TICK_LAST);
  // A load is decoded one cycle after capture (r_pend); no step may land in that cycle.
  assign w_step = w_tick && !r_pend && (r_state != S_IDLE) && (r_step_cnt == r_rate_q - 8'd1);

  always_comb begin
    w_duty_step = r_duty;
    if (r_state == S_UP) begin
      if (r_duty < 7'd100) w_duty_step = r_duty + 7'd1;
    end else if (r_state == S_DOWN) begin
      if (r_duty > 7'd0) w_duty_step = r_duty - 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next     = r_state;
    w_duty_next      = r_duty;
    w_target_next    = r_target_q;
    w_rate_next      = r_rate_q;
    w_tick_next      = r_tick_cnt;
    w_step_next      = r_step_cnt;
    w_pend_next      = 1'b0;
    w_done_pend_next = 1'b0;
    w_done_next      = r_done_pend;

    if (r_state != S_IDLE || r_pend) begin
      w_tick_next = w_tick ? '0 : r_tick_cnt + 1'b1;
      if (w_tick) w_step_next = r_step_cnt + 8'd1;
    end else begin
      w_tick_next = '0;
      w_step_next = '0;
    end

    if (estop) begin
      w_state_next  = S_IDLE;
      w_duty_next   = 7'd0;
      w_target_next = 7'd0;
      w_tick_next   = '0;
      w_step_next   = '0;
      w_done_next   = 1'b0;
    end else if (load) begin
      w_target_next = w_target_clamped;
      w_rate_next   = rate;
      w_tick_next   = '0;
      w_step_next   = '0;
      w_pend_next   = 1'b1;
    end else if (r_pend) begin
      if (r_target_q == r_duty) begin
        w_state_next = S_IDLE;
        w_done_next  = 1'b1;
      end else if (r_rate_q == 8'd0) begin
        w_state_next     = S_IDLE;
        w_duty_next      = r_target_q;
        w_done_pend_next = 1'b1;
      end else if (r_target_q > r_duty) begin
        w_state_next = S_UP;
      end else begin
        w_state_next = S_DOWN;
      end
    end else if (w_step) begin
      w_step_next = '0;
      w_duty_next = w_duty_step;
      if (w_duty_step == r_target_q) begin
        w_state_next     = S_IDLE;
        w_done_pend_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_duty      <= 7'd0;
      r_target_q  <= 7'd0;
      r_rate_q    <= 8'd0;
      r_tick_cnt  <= '0;
      r_step_cnt  <= 8'd0;
      r_pend      <= 1'b0;
      r_done_pend <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_duty      <= w_duty_next;
      r_target_q  <= w_target_next;
      r_rate_q    <= w_rate_next;
      r_tick_cnt  <= w_tick_next;
      r_step_cnt  <= w_step_next;
      r_pend      <= w_pend_next;
      r_done_pend <= w_done_pend_next;
      r_done      <= w_done_next;
    end
  end

  assign duty = r_duty;
  assign busy = (r_state != S_IDLE);
  assign dir  = (r_state == S_UP);
  assign done = r_done;

endmodule
